// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the 5-stage RV32I pipeline.
// Owns the PC, issues one imem read at a time, and holds the IF/ID register.
// While the pipe is frozen, a returned word is parked in a one-entry buffer.
// After a redirect, a response that is already in flight is drained and
// thrown away.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        fd_valid,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_inst,
    output logic [63:0] fd_order
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] req_addr;
    logic [31:0] req_next;
    logic [31:0] hold_inst;
    logic [31:0] hold_next;
    logic [63:0] order;
    logic [63:0] order_next;
    logic        fd_valid_next;
    logic [31:0] fd_pc_next;
    logic [31:0] fd_inst_next;
    logic [63:0] fd_order_next;
    logic [31:0] target;

    // Clear the low two bits so that every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Advance to the next sequential word. The sum wraps modulo 2^32.
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    assign target = align_word(redirect_pc);

    // The request is held steady until its response arrives.
    // No request is presented while parked in HOLD or while reset is high.
    always_comb begin
        imem_addr  = req_addr;
        imem_rmask = (!rst && state != HOLD) ? 4'hF : 4'h0;
    end

    // Next-state logic for the fetch FSM, the PC and the IF/ID contents.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_next      = req_addr;
        hold_next     = hold_inst;
        order_next    = order;
        fd_valid_next = fd_valid;
        fd_pc_next    = fd_pc;
        fd_inst_next  = fd_inst;
        fd_order_next = fd_order;

        case (state)
            FETCH: begin
                if (!freeze) begin
                    if (redirect) begin
                        // Squash whatever comes back for the old stream.
                        fd_valid_next = 1'b0;
                        fd_inst_next  = NOP;
                        pc_next       = target;
                        if (imem_resp) begin
                            req_next = target;
                        end else begin
                            state_next = DROP;
                        end
                    end else if (imem_resp) begin
                        fd_valid_next = 1'b1;
                        fd_pc_next    = req_addr;
                        fd_inst_next  = imem_rdata;
                        fd_order_next = order;
                        order_next    = order + 64'd1;
                        pc_next       = next_word(req_addr);
                        req_next      = next_word(req_addr);
                    end else begin
                        fd_valid_next = 1'b0;
                        fd_inst_next  = NOP;
                    end
                end else if (imem_resp) begin
                    // Decode is stalled, so park the word until the pipe moves.
                    hold_next  = imem_rdata;
                    pc_next    = next_word(req_addr);
                    state_next = HOLD;
                end
            end

            HOLD: begin
                if (!freeze) begin
                    state_next = FETCH;
                    if (redirect) begin
                        fd_valid_next = 1'b0;
                        fd_inst_next  = NOP;
                        pc_next       = target;
                        req_next      = target;
                    end else begin
                        // pc already points one word past the parked instruction.
                        fd_valid_next = 1'b1;
                        fd_pc_next    = pc - 32'd4;
                        fd_inst_next  = hold_inst;
                        fd_order_next = order;
                        order_next    = order + 64'd1;
                        req_next      = pc;
                    end
                end
            end

            DROP: begin
                if (!freeze) begin
                    fd_valid_next = 1'b0;
                    fd_inst_next  = NOP;
                    if (redirect) begin
                        pc_next = target;
                    end
                end
                if (imem_resp) begin
                    // The stale word is thrown away; resume at the latest target.
                    req_next   = (!freeze && redirect) ? target : pc;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // State, PC, order counter and IF/ID register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            hold_inst <= 32'd0;
            order     <= 64'd0;
            fd_valid  <= 1'b0;
            fd_pc     <= 32'd0;
            fd_inst   <= NOP;
            fd_order  <= 64'd0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            req_addr  <= req_next;
            hold_inst <= hold_next;
            order     <= order_next;
            fd_valid  <= fd_valid_next;
            fd_pc     <= fd_pc_next;
            fd_inst   <= fd_inst_next;
            fd_order  <= fd_order_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. Directed stimulus pushes the expected instruction
// deliveries into a queue. A monitor pops an entry whenever IF/ID loads a
// valid instruction, and otherwise checks that a bubble was loaded.
module tb_fetch_stage;

    localparam logic [31:0] A   = 32'h1eceb000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        fd_valid;
    logic [31:0] fd_pc;
    logic [31:0] fd_inst;
    logic [63:0] fd_order;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [63:0] order;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    fetch_stage #(.RESET_PC(A)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .fd_valid    (fd_valid),
        .fd_pc       (fd_pc),
        .fd_inst     (fd_inst),
        .fd_order    (fd_order)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs. Outputs are read 1 time unit after the edge.
    task automatic drive(input logic r, input logic rs, input logic [31:0] d,
                         input logic fz, input logic rd, input logic [31:0] rp);
        rst         = r;
        imem_resp   = rs;
        imem_rdata  = d;
        freeze      = fz;
        redirect    = rd;
        redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'hx, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resp(input logic [31:0] d);
        drive(1'b0, 1'b1, d, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] i, input logic [63:0] o);
        exp_t e;
        e.pc    = p;
        e.inst  = i;
        e.order = o;
        exp_q.push_back(e);
    endtask

    task automatic chk_req(input string nm, input logic [31:0] addr, input logic [3:0] mask);
        chk({nm, "_rmask"}, {60'd0, imem_rmask}, {60'd0, mask});
        if (mask == 4'hF) chk({nm, "_addr"}, {32'd0, imem_addr}, {32'd0, addr});
    endtask

    // Monitor: after every edge where IF/ID was allowed to load, check what it loaded.
    initial begin : monitor
        logic loaded;
        exp_t e;
        forever begin
            @(posedge clk);
            loaded = rst || !freeze;
            @(negedge clk);
            if (loaded) begin
                if (fd_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_unexpected: got pc=%h inst=%h expected no delivery", fd_pc, fd_inst);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", {32'd0, fd_pc}, {32'd0, e.pc});
                        chk("sb_inst", {32'd0, fd_inst}, {32'd0, e.inst});
                        chk("sb_order", fd_order, e.order);
                    end
                end else begin
                    chk("bubble_inst", {32'd0, fd_inst}, {32'd0, NOP});
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; freeze = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_resp = 1'b0; imem_rdata = 32'h0;

        // Reset, with a stray response that must be ignored.
        drive(1'b1, 1'b1, 32'hdeadbeef, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst_rmask", {60'd0, imem_rmask}, 64'd0);
        chk("rst_valid", {63'd0, fd_valid}, 64'd0);
        chk("rst_pc", {32'd0, fd_pc}, 64'd0);
        chk("rst_inst", {32'd0, fd_inst}, {32'd0, NOP});
        chk("rst_order", fd_order, 64'd0);
        rst = 1'b0;
        #1;
        chk_req("first_req", A, 4'hF);

        // Back-to-back fetches with data equal to the address.
        for (int k = 0; k < 3; k++) begin
            push(A + 32'(4 * k), A + 32'(4 * k), 64'(k));
            resp(A + 32'(4 * k));
            chk_req("b2b", A + 32'(4 * (k + 1)), 4'hF);
            chk("b2b_valid", {63'd0, fd_valid}, 64'd1);
        end

        // Fresh reset, then a response arrives during a 3-cycle freeze.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst2_order", fd_order, 64'd0);
        drive(1'b0, 1'b1, 32'h00500093, 1'b1, 1'b0, 32'h0);
        chk_req("hold1", A, 4'h0);
        chk("hold1_valid", {63'd0, fd_valid}, 64'd0);
        drive(1'b0, 1'b1, 32'hbadbad00, 1'b1, 1'b0, 32'h0);
        chk_req("hold2", A, 4'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_req("hold3", A, 4'h0);
        chk("hold3_inst", {32'd0, fd_inst}, {32'd0, NOP});
        push(A, 32'h00500093, 64'd0);
        idle();
        chk_req("unfreeze", A + 32'd4, 4'hF);

        // Redirect while the request to A+8 is outstanding: drain it in DROP.
        push(A + 32'd4, 32'h11111111, 64'd1);
        resp(32'h11111111);
        chk_req("pre_drop", A + 32'd8, 4'hF);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1eceb103);
        chk_req("drop1", A + 32'd8, 4'hF);
        idle();
        chk_req("drop2", A + 32'd8, 4'hF);
        resp(32'hdeaddead);
        chk_req("after_drop", 32'h1eceb100, 4'hF);
        push(32'h1eceb100, 32'h22222222, 64'd2);
        resp(32'h22222222);

        // Redirect in the same cycle as a response.
        drive(1'b0, 1'b1, 32'hbad00bad, 1'b0, 1'b1, 32'h1eceb200);
        chk("redir_resp_valid", {63'd0, fd_valid}, 64'd0);
        chk_req("redir_resp", 32'h1eceb200, 4'hF);
        push(32'h1eceb200, 32'h33333333, 64'd3);
        resp(32'h33333333);

        // Redirect on release from HOLD discards the parked word.
        drive(1'b0, 1'b1, 32'h44444444, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1eceb300);
        chk_req("hold_redir", 32'h1eceb300, 4'hF);

        // Redirect to the top word, then fetch across the 2^32 wrap.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hffffffff);
        resp(32'hdeaddead);
        chk_req("wrap_req", 32'hfffffffc, 4'hF);
        push(32'hfffffffc, 32'h55555555, 64'd4);
        resp(32'h55555555);
        chk_req("wrap_next", 32'h0, 4'hF);

        // Reset while a response arrives for the outstanding request.
        drive(1'b1, 1'b1, 32'h66666666, 1'b0, 1'b0, 32'h0);
        chk("rst3_valid", {63'd0, fd_valid}, 64'd0);
        chk("rst3_pc", {32'd0, fd_pc}, 64'd0);
        chk("rst3_order", fd_order, 64'd0);
        rst = 1'b0;
        #1;
        chk_req("rst3_req", A, 4'hF);
        push(A, 32'h77777777, 64'd0);
        resp(32'h77777777);

        // Slow memory: the response arrives 4 cycles after each request.
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < 3; g++) begin
                idle();
                chk("slow_gap_valid", {63'd0, fd_valid}, 64'd0);
                chk_req("slow_gap", A + 32'(4 * (k + 1)), 4'hF);
            end
            push(A + 32'(4 * (k + 1)), 32'h80000000 + 32'(k), 64'(k + 1));
            resp(32'h80000000 + 32'(k));
        end

        idle();
        idle();
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the PC, drives the imem request interface and holds the IF/ID pipeline register.
- Consumes the global `freeze` produced by the stall unit and the branch/jump `redirect` from EX.
- Keeps one imem request outstanding at a time.
- Buffers a returned instruction while the pipe is frozen, and discards in-flight responses made stale by a redirect.

Parameters:
- RESET_PC, 32'h1eceb000, PC of the first fetch after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- freeze  in  1  pipeline freeze from stall unit; 1 = hold all pipeline registers
- redirect  in  1  EX control-flow redirect request
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0
- imem_addr  out  32  fetch address; word aligned
- imem_rmask  out  4  4'hF = read request active, 4'h0 = idle
- imem_rdata  in  32  returned instruction word
- imem_resp  in  1  one-cycle response strobe for the outstanding request
- fd_valid  out  1  IF/ID register holds a real instruction
- fd_pc  out  32  PC of the instruction in IF/ID
- fd_inst  out  32  instruction in IF/ID; 32'h13 when not valid
- fd_order  out  64  retirement order tag for RVFI

Behaviour:
- Reset (rst=1 at a clk edge):
  - pc=RESET_PC, req_addr=RESET_PC, state=FETCH, order=0.
  - fd_valid=0, fd_pc=0, fd_inst=32'h13, fd_order=0, hold buffer cleared.
  - imem_rmask=0 while rst is high. The first request is presented in the first cycle after rst falls.
  - Reset mid-request abandons the request. Any imem_resp in the reset cycle is ignored.
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the outstanding request.
  - order: 64-bit counter.
  - hold_inst: one-entry buffer.
  - state in {FETCH, HOLD, DROP}.
- Interface rules:
  - imem_addr=req_addr in FETCH and DROP.
  - imem_rmask=4'hF in FETCH and DROP, 0 in HOLD.
  - imem_addr and imem_rmask are stable from request until the imem_resp cycle.
  - A new address may be presented the cycle after imem_resp (back-to-back fetch).
  - imem_resp in HOLD is ignored.
- `redirect` is sampled only when freeze=0. EX holds it while frozen.
- FETCH:
  - resp=1, freeze=0, redirect=0:
    - fd_valid<=1, fd_pc<=req_addr, fd_inst<=imem_rdata, fd_order<=order.
    - order++, pc<=req_addr+4, req_addr<=req_addr+4.
    - Stay in FETCH.
  - resp=1, freeze=1:
    - hold_inst<=imem_rdata, pc<=req_addr+4, go to HOLD.
    - IF/ID holds its value.
  - resp=0, freeze=0, redirect=0: IF/ID loads a bubble (fd_valid=0, fd_inst=32'h13).
  - freeze=0, redirect=1:
    - IF/ID loads a bubble.
    - pc<=redirect_pc & ~3.
    - If resp=1 this cycle, the response is discarded, req_addr<=target, stay in FETCH.
    - If resp=0, go to DROP with req_addr unchanged.
- HOLD:
  - freeze=1: hold all state.
  - freeze=0, redirect=0:
    - fd_valid<=1, fd_pc<=pc-4, fd_inst<=hold_inst, fd_order<=order.
    - order++, req_addr<=pc, go to FETCH.
  - freeze=0, redirect=1: discard hold_inst, load a bubble, pc<=req_addr<=target, go to FETCH.
- DROP:
  - Keep requesting the old req_addr.
  - On imem_resp: discard the data, req_addr<=pc, go to FETCH.
  - A further redirect while in DROP updates pc only.
  - IF/ID loads bubbles while freeze=0.
- Arithmetic: pc+4 wraps modulo 2^32; order wraps modulo 2^64.
- Only a delivered instruction increments order. Bubbles and dropped responses do not.

Test Plan:
- Reset, then imem_resp every cycle with the data equal to its address, freeze=0:
  - fd_pc sequence is 1eceb000, 1eceb004, 1eceb008.
  - fd_order is 0, 1, 2 and fd_valid=1 throughout.
- Response with data 32'h00500093 arrives while freeze=1 for 3 cycles:
  - imem_rmask=0 during HOLD and IF/ID is unchanged.
  - On unfreeze, fd_inst=00500093 and fd_pc=1eceb000, and the next request goes to 1eceb004.
- redirect=1 with redirect_pc=32'h1eceb103 while the request to 1eceb008 is outstanding (no resp):
  - Enters DROP. The later resp for 1eceb008 is never delivered.
  - The next request is to 1eceb100 and fd_pc=1eceb100 on its response.
- redirect coincident with resp:
  - The response is discarded and fd_valid=0 that cycle.
  - The following imem_addr is the target.
- rst asserted while a request is outstanding and imem_resp arrives in the same cycle:
  - Outputs return to reset values and order=0.
  - The first post-reset request is to RESET_PC.
- Slow memory with resp 4 cycles after each request:
  - fd_valid=0 with fd_inst=32'h13 in the gap cycles.
  - order increments exactly once per delivered instruction.
